// File: rtl/fp_sum_sequencer.sv
// Folds a last-delimited stream of IEEE-754 doubles into one sum by issuing
// sequential requests to an external double_adder, then presents the result downstream.
module fp_sum_sequencer #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             add_valid,
    output logic [63:0]      add_a,
    output logic [63:0]      add_b,
    input  logic [63:0]      add_z,
    input  logic             add_done,
    output logic             sum_valid,
    output logic [63:0]      sum_data,
    output logic [CNT_W-1:0] sum_count,
    input  logic             sum_ready,
    output logic             timeout_err
);
    localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {EMPTY, ACC, BUSY, OUT} state_t;

    state_t           state;
    logic [63:0]      acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             last_r;
    logic [WD_W-1:0]  wd;
    logic             wd_expired;

    assign in_ready = (state == EMPTY) || (state == ACC);

    always_comb begin
        count_inc  = (&count) ? count : count + 1'b1;
        wd_expired = (TIMEOUT != 0) && (wd == WD_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            acc         <= '0;
            count       <= '0;
            last_r      <= 1'b0;
            wd          <= '0;
            add_valid   <= 1'b0;
            add_a       <= '0;
            add_b       <= '0;
            sum_valid   <= 1'b0;
            sum_data    <= '0;
            sum_count   <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    // First term seeds the accumulator without an adder round-trip
                    if (in_valid) begin
                        acc   <= in_data;
                        count <= CNT_W'(1);
                        if (in_last) begin
                            state     <= OUT;
                            sum_valid <= 1'b1;
                            sum_data  <= in_data;
                            sum_count <= CNT_W'(1);
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        add_a     <= acc;
                        add_b     <= in_data;
                        add_valid <= 1'b1;
                        last_r    <= in_last;
                        count     <= count_inc;
                        wd        <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (add_done) begin
                        acc       <= add_z;
                        add_valid <= 1'b0;
                        if (last_r) begin
                            state     <= OUT;
                            sum_valid <= 1'b1;
                            sum_data  <= add_z;
                            sum_count <= count;
                        end else begin
                            state <= ACC;
                        end
                    end else if (wd_expired) begin
                        // Give up on the adder and emit the pre-add accumulator
                        timeout_err <= 1'b1;
                        add_valid   <= 1'b0;
                        state       <= OUT;
                        sum_valid   <= 1'b1;
                        sum_data    <= acc;
                        sum_count   <= count;
                    end else if (TIMEOUT != 0) begin
                        wd <= wd + 1'b1;
                    end
                end
                OUT: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                        state     <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule
